// File: rtl/fog_demodulator_if.sv
// Sample/status inputs and period results for the PIG square-wave demodulator.
// The bench drives through master; the demodulator sits on slave.
interface fog_demodulator_if #(
    parameter int ADC_BIT = 14,
    parameter int ACC_BIT = 24
);
    logic                      i_en;
    logic signed [ADC_BIT-1:0] i_adc_data;
    logic                      i_status;
    logic [15:0]               i_blank_cnt;
    logic signed [ACC_BIT:0]   o_err;
    logic                      o_err_valid;
    logic signed [ACC_BIT-1:0] o_sum_H;
    logic signed [ACC_BIT-1:0] o_sum_L;
    logic                      o_sat;

    modport master (
        output i_en, i_adc_data, i_status, i_blank_cnt,
        input  o_err, o_err_valid, o_sum_H, o_sum_L, o_sat
    );

    modport slave (
        input  i_en, i_adc_data, i_status, i_blank_cnt,
        output o_err, o_err_valid, o_sum_H, o_sum_L, o_sat
    );
endinterface

// File: rtl/fog_demodulator.sv
// Square-wave synchronous demodulator: integrates HIGH and LOW halves with
// post-transition blanking and reports sum_H - sum_L once per period.
module fog_demodulator #(
    parameter int ADC_BIT = 14,
    parameter int ACC_BIT = 24
) (
    input logic              i_clk,
    input logic              i_rst,
    fog_demodulator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ACC
    } state_e;

    localparam logic signed [ACC_BIT-1:0] ACC_MAX =
        {1'b0, {(ACC_BIT-1){1'b1}}};
    localparam logic signed [ACC_BIT-1:0] ACC_MIN =
        {1'b1, {(ACC_BIT-1){1'b0}}};

    state_e                    state_q;
    logic                      status_q;
    logic [15:0]               blank_q;
    logic signed [ACC_BIT-1:0] acc_q;
    logic                      sat_q;
    logic signed [ACC_BIT-1:0] sum_l_q;
    logic                      sat_l_q;
    logic                      have_l_q;
    logic signed [ACC_BIT:0]   err_q;
    logic                      err_valid_q;
    logic signed [ACC_BIT-1:0] sum_h_out_q;
    logic signed [ACC_BIT-1:0] sum_l_out_q;
    logic                      sat_out_q;

    logic                      edge_w;
    logic                      fall_w;
    logic                      rise_w;
    logic signed [ACC_BIT-1:0] sample_ext;
    logic signed [ACC_BIT:0]   sum_wide;
    logic                      ovf_w;
    logic signed [ACC_BIT-1:0] acc_add_d;
    logic signed [ACC_BIT:0]   err_d;
    state_e                    start_state_d;
    logic signed [ACC_BIT-1:0] start_acc_d;

    always_comb begin
        edge_w     = bus.i_status != status_q;
        fall_w     = status_q & ~bus.i_status;
        rise_w     = ~status_q & bus.i_status;
        sample_ext = {{(ACC_BIT-ADC_BIT){bus.i_adc_data[ADC_BIT-1]}},
                      bus.i_adc_data};
        sum_wide   = {acc_q[ACC_BIT-1], acc_q}
                   + {sample_ext[ACC_BIT-1], sample_ext};
        ovf_w      = sum_wide[ACC_BIT] ^ sum_wide[ACC_BIT-1];
        acc_add_d  = sum_wide[ACC_BIT-1:0];
        if (ovf_w) begin
            acc_add_d = sum_wide[ACC_BIT] ? ACC_MIN : ACC_MAX;
        end
        err_d = {acc_q[ACC_BIT-1], acc_q} - {sum_l_q[ACC_BIT-1], sum_l_q};
        // Edge-cycle sample counts as the first blanked one when blank >= 1.
        start_state_d = S_BLANK;
        start_acc_d   = '0;
        unique case (1'b1)
            (bus.i_blank_cnt == 16'd0): begin
                start_state_d = S_ACC;
                start_acc_d   = sample_ext;
            end
            (bus.i_blank_cnt == 16'd1): start_state_d = S_ACC;
            default: start_state_d = S_BLANK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            status_q    <= 1'b0;
            blank_q     <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            sum_l_q     <= '0;
            sat_l_q     <= 1'b0;
            have_l_q    <= 1'b0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            sum_h_out_q <= '0;
            sum_l_out_q <= '0;
            sat_out_q   <= 1'b0;
        end else begin
            status_q    <= bus.i_status;
            err_valid_q <= 1'b0;
            if (!bus.i_en) begin
                state_q  <= S_IDLE;
                blank_q  <= '0;
                acc_q    <= '0;
                sat_q    <= 1'b0;
                sum_l_q  <= '0;
                sat_l_q  <= 1'b0;
                have_l_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (fall_w) begin
                            have_l_q <= 1'b0;
                            blank_q  <= bus.i_blank_cnt;
                            acc_q    <= start_acc_d;
                            sat_q    <= 1'b0;
                            state_q  <= start_state_d;
                        end
                    end
                    default: begin
                        if (edge_w) begin
                            if (rise_w) begin
                                sum_l_q  <= acc_q;
                                sat_l_q  <= sat_q;
                                have_l_q <= 1'b1;
                            end else if (have_l_q) begin
                                sum_h_out_q <= acc_q;
                                sum_l_out_q <= sum_l_q;
                                err_q       <= err_d;
                                sat_out_q   <= sat_q | sat_l_q;
                                err_valid_q <= 1'b1;
                            end
                            blank_q <= bus.i_blank_cnt;
                            acc_q   <= start_acc_d;
                            sat_q   <= 1'b0;
                            state_q <= start_state_d;
                        end else if (state_q == S_BLANK) begin
                            blank_q <= blank_q - 16'd1;
                            if (blank_q == 16'd2) begin
                                state_q <= S_ACC;
                            end
                        end else begin
                            acc_q <= acc_add_d;
                            if (ovf_w) begin
                                sat_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.o_err       = err_q;
    assign bus.o_err_valid = err_valid_q;
    assign bus.o_sum_H     = sum_h_out_q;
    assign bus.o_sum_L     = sum_l_out_q;
    assign bus.o_sat       = sat_out_q;
endmodule

// File: tb/tb_fog_demodulator.sv
// Scoreboard bench for fog_demodulator: directed half-periods push expected
// period results; a monitor pops them on every o_err_valid pulse.
module tb_fog_demodulator;
    localparam int ADC = 14;
    localparam int ACC = 16;

    typedef struct {
        longint h;
        longint l;
        longint e;
        bit     s;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   en_v = 1'b1;
    int   blank_v = 2;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fog_demodulator_if #(.ADC_BIT(ADC), .ACC_BIT(ACC)) bus ();

    fog_demodulator #(.ADC_BIT(ADC), .ACC_BIT(ACC)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    function automatic void check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (bus.o_err_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid at cycle %0d expected none",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("err", bus.o_err, e.e);
                check("sum_H", bus.o_sum_H, e.h);
                check("sum_L", bus.o_sum_L, e.l);
                check("sat", bus.o_sat, e.s);
            end
        end
    end

    task automatic half(bit st, int adc, int n, bit push = 0,
                        longint eh = 0, longint el = 0, bit es = 0);
        logic [ADC-1:0] s;
        s = adc[ADC-1:0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (push && i == 0) q.push_back('{eh, el, eh - el, es, cyc + 1});
            bus.i_en        = en_v;
            bus.i_blank_cnt = blank_v[15:0];
            bus.i_status    = st;
            bus.i_adc_data  = s;
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_err"}, bus.o_err, 0);
        check({tag, "_sum_H"}, bus.o_sum_H, 0);
        check({tag, "_sum_L"}, bus.o_sum_L, 0);
        check({tag, "_sat"}, bus.o_sat, 0);
        check({tag, "_valid"}, bus.o_err_valid, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_en        = 1'b1;
        bus.i_status    = 1'b0;
        bus.i_adc_data  = '0;
        bus.i_blank_cnt = 16'd2;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // blank=2, +/-100 then constant 50
        half(1, 100, 8);
        half(0, -100, 8);
        half(1, 100, 8);
        half(0, -100, 8, 1, 600, -600, 0);
        half(1, 100, 8);
        half(0, -100, 8, 1, 600, -600, 0);
        half(1, 50, 8);
        half(0, 50, 8, 1, 300, -600, 0);
        half(1, 50, 8);
        half(0, 50, 8, 1, 300, 300, 0);

        // blank longer than the half
        blank_v = 10;
        half(1, 50, 8);
        half(0, 50, 8, 1, 0, 300, 0);
        half(1, 50, 8);
        half(0, 50, 8, 1, 0, 0, 0);

        // saturation both directions, full-width err
        blank_v = 0;
        half(1, 8191, 8);
        half(0, 0, 8, 1, 32767, 0, 1);
        half(1, -8192, 8);
        half(0, -8192, 8, 1, -32768, 0, 1);
        half(1, 8191, 8);
        half(0, 0, 8, 1, 32767, -32768, 1);
        half(1, 1, 8);
        half(0, 0, 8, 1, 8, 0, 0);

        // reset mid-HIGH
        half(1, 1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        half(1, 1, 3);
        half(0, 2, 8);
        half(1, 3, 8);
        half(0, 0, 8, 1, 24, 16, 0);

        // enable dropped mid-LOW
        half(1, 5, 8);
        half(0, -5, 3, 1, 40, 0, 0);
        en_v = 1'b0;
        half(0, -5, 3);
        check("en_low_err_hold", bus.o_err, 40);
        check("en_low_sum_H_hold", bus.o_sum_H, 40);
        en_v = 1'b1;
        half(0, -5, 2);
        half(1, 5, 8);
        half(0, -5, 8);
        half(1, 5, 8);
        half(0, -5, 8, 1, 40, -40, 0);

        // one-cycle halves
        half(1, 5, 1);
        half(0, -3, 1, 1, 5, -40, 0);
        for (int k = 0; k < 4; k++) begin
            half(1, 5, 1);
            half(0, -3, 1, 1, 5, -3, 0);
        end

        half(0, 0, 10);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fog_demodulator.md
Name: fog_demodulator

Overview:
Synchronous square-wave demodulator for the PIG loop. It consumes signed ADC samples with the status bit produced by the square-wave modulation generator. Per modulation period it integrates the HIGH half and the LOW half separately, skipping a programmable number of post-transition samples, and emits the error difference sum_H - sum_L. The output feeds the loop filter and step/ramp logic downstream.

Parameters:
ADC_BIT, 14, width of signed ADC sample
ACC_BIT, 24, width of signed half-period accumulators; error output is ACC_BIT+1

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_en  in  1  demodulator enable; low forces IDLE
i_adc_data  in  ADC_BIT  signed ADC sample, one per clock
i_status  in  1  modulation half indicator (1 = HIGH half, 0 = LOW half)
i_blank_cnt  in  16  samples to discard after each status transition
o_err  out  ACC_BIT+1  signed sum_H - sum_L of last full period
o_err_valid  out  1  one-cycle pulse when o_err updates
o_sum_H  out  ACC_BIT  signed HIGH-half sum of last full period
o_sum_L  out  ACC_BIT  signed LOW-half sum of last full period
o_sat  out  1  saturation occurred in either half of the reported period

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0, status_d=0, accumulators 0, blank counter 0, have_L=0, state IDLE.
- Edge detect: status_d registers i_status each cycle. Edge cycle = cycle where i_status != status_d. Edge cycle is cycle 0 of the new half.
- States: IDLE, BLANK, ACC.
- IDLE: waits for a falling edge (status_d=1, i_status=0). On it, latch blank_left=i_blank_cnt, clear acc and sat_flag, have_L=0, enter BLANK, or ACC if i_blank_cnt=0 (edge-cycle sample is then accumulated). Rising edges in IDLE are ignored.
- BLANK: sample discarded. blank_left decrements. The cycle where blank_left reaches 1 is the last discarded sample; ACC follows.
- ACC: acc <= sat(acc + sign-extended i_adc_data). On overflow, clamp to +2^(ACC_BIT-1)-1 or -2^(ACC_BIT-1) and set sat_flag for the current half.
- Any edge, in BLANK or ACC: close the current half with the sample from cycle t-1 as its last contribution. Reload blank_left=i_blank_cnt. Clear acc and the half sat flag, then apply the blank/ACC rule to the edge-cycle sample.
  - Rising edge (LOW ends): sum_L_hold <= acc, satL <= flag, have_L <= 1.
  - Falling edge (HIGH ends), have_L=1: at the same clock edge, o_sum_H <= acc, o_sum_L <= sum_L_hold, o_err <= acc - sum_L_hold at full ACC_BIT+1 width (never overflows), o_sat <= satH|satL, o_err_valid <= 1.
  - Falling edge, have_L=0: no output.
- Latency: a falling edge detected in cycle t makes outputs visible and o_err_valid high in cycle t+1 only. Outputs hold until the next update.
- Blank longer than the half: no samples accumulated, that half sums to 0, the edge still closes it normally.
- i_blank_cnt is sampled only at edges. Mid-half changes take effect at the next half.
- i_en=0: next state IDLE, accumulators/have_L cleared, o_err_valid=0. o_err/o_sum_*/o_sat keep their last values. On re-enable, wait for a falling edge.
- Reset mid-operation: as reset. The first valid output requires a falling edge, a full LOW half, a rising edge, a full HIGH half, then a falling edge.
- Status toggling every cycle (half length 1): each edge closes a 1-sample half. Output every 2 cycles when blank=0.

Test Plan:
- ADC_BIT=14, ACC_BIT=24, blank=2, 8-cycle halves, ADC=+100 in HIGH and -100 in LOW -> every falling edge after the first full period: sum_H=600, sum_L=-600, err=1200, valid 1 cycle, sat=0.
- Same timing, constant ADC=50 -> err=0, sum_H=sum_L=300. Blank=10 (> half) -> sums 0, err 0, valid still pulses.
- ACC_BIT=16, blank=0, ADC=8191 for the whole HIGH half, 0 in LOW, 8-cycle halves -> sum_H=32767 (clamped from 65528), sat=1. Next period with ADC=1 -> sum_H=8, sat=0.
- Reset asserted mid-HIGH, status continuing -> all outputs 0 next cycle. No valid at the next falling edge. First valid at the second falling edge after reset.
- i_en dropped for 3 cycles mid-LOW, then re-raised -> no valid until a falling edge, a full L+H, and another falling edge. Prior o_err retained meanwhile.
- 1-cycle halves, blank=0, ADC alternating +5 (H) / -3 (L) -> err=8, valid every 2nd cycle.
